// File: rtl/axi_fifo_lvl.sv
`timescale 1ns/1ps
// First-word-fall-through valid/ready FIFO of arbitrary depth.
// Provides registered occupancy, watermark flags, a synchronous flush and a high-water mark.
module axi_fifo_lvl #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 5,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             rdy_in,
  output logic             vld_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             rdy_out,
  input  logic             flush,
  output logic [CW-1:0]    level,
  output logic [CW-1:0]    max_level,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] level_reg, level_next;
  logic [CW-1:0] max_level_reg, max_level_next;
  logic          almost_full_reg, almost_full_next;
  logic          almost_empty_reg, almost_empty_next;
  logic          push, pop;

  // Explicit wrap so that non-power-of-two depths cycle through exactly DEPTH slots.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshakes look only at registered occupancy, so rdy_out never reaches rdy_in.
  assign rdy_in   = !rst && !flush && (level_reg != CW'(DEPTH));
  assign vld_out  = !rst && !flush && (level_reg != '0);
  assign data_out = vld_out ? mem[rd_ptr_reg] : '0;

  assign push = vld_in && rdy_in;
  assign pop  = vld_out && rdy_out;

  always_comb begin
    wr_ptr_next       = wr_ptr_reg;
    rd_ptr_next       = rd_ptr_reg;
    level_next        = level_reg;
    max_level_next    = max_level_reg;
    almost_full_next  = almost_full_reg;
    almost_empty_next = almost_empty_reg;
    if (flush) begin
      wr_ptr_next       = '0;
      rd_ptr_next       = '0;
      level_next        = '0;
      max_level_next    = '0;
      almost_full_next  = (AF_THRESH == 0);
      almost_empty_next = 1'b1;
    end else begin
      if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   level_next = level_reg + 1'b1;
        2'b01:   level_next = level_reg - 1'b1;
        default: level_next = level_reg;
      endcase
      max_level_next    = (level_next > max_level_reg) ? level_next : max_level_reg;
      almost_full_next  = (level_next >= CW'(AF_THRESH));
      almost_empty_next = (level_next <= CW'(AE_THRESH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      level_reg        <= '0;
      max_level_reg    <= '0;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      level_reg        <= level_next;
      max_level_reg    <= max_level_next;
      almost_full_reg  <= almost_full_next;
      almost_empty_reg <= almost_empty_next;
    end
  end

  // Storage carries no reset; push is already blocked during rst and flush.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= data_in;
  end

  assign level        = level_reg;
  assign max_level    = max_level_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;

endmodule
